// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: four-slot TDM frame demultiplexer with SOF hunt/lock framing
module tdm_demux_4ch #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           in_valid,
  input  logic           in_sof,
  input  logic [W-1:0]   in_data,
  output logic [4*W-1:0] ch_data,
  output logic [3:0]     ch_valid,
  output logic           frame_done,
  output logic           sync_err,
  output logic           locked
);
  localparam logic HUNT   = 1'b0;
  localparam logic LOCKED = 1'b1;
  logic       st;
  logic [1:0] slot;
  logic       acc;
  logic       lk;
  logic       hit;
  logic       good;
  logic       miss;
  logic       early;
  logic       wr;
  logic [1:0] ws;
  assign acc    = enable && in_valid;
  assign lk     = acc && st == LOCKED;
  assign hit    = acc && st == HUNT && in_sof;
  assign good   = lk && (in_sof == (slot == 2'd0));
  assign miss   = lk && slot == 2'd0 && !in_sof;
  assign early  = lk && slot != 2'd0 && in_sof;
  assign wr     = hit || good || early;
  assign ws     = in_sof ? 2'd0 : slot;
  assign locked = st == LOCKED;
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= HUNT;
      slot       <= 2'd0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= wr ? 4'b0001 << ws : 4'b0000;
      frame_done <= wr && ws == 2'd3;
      sync_err   <= miss || early;
      if (wr) begin
        ch_data[ws*W +: W] <= in_data;
        slot               <= ws + 2'd1;
        st                 <= LOCKED;
      end else if (miss) begin
        slot <= 2'd0;
        st   <= HUNT;
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: directed and randomized checks of tdm_demux_4ch against a frame-level model
module tb_tdm_demux_4ch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = '0;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;
  logic        frame_done;
  logic        sync_err;
  logic        locked;
  int tests = 0;
  int fails = 0;
  logic [7:0] m_ch[4];
  bit         m_lock;
  int         m_slot;
  logic [3:0] m_v;
  bit         m_fd;
  bit         m_err;
  tdm_demux_4ch #(.W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .ch_data(ch_data), .ch_valid(ch_valid),
    .frame_done(frame_done), .sync_err(sync_err), .locked(locked)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] m_data();
    return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
  endfunction
  task automatic step(input logic r, input logic e, input logic v, input logic s, input logic [7:0] d);
    rst = r;
    enable = e;
    in_valid = v;
    in_sof = s;
    in_data = d;
    m_v = 4'b0000;
    m_fd = 0;
    m_err = 0;
    if (r) begin
      for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
      m_lock = 0;
      m_slot = 0;
    end else if (e && v) begin
      if (!m_lock) begin
        if (s) begin
          m_ch[0] = d;
          m_v = 4'b0001;
          m_slot = 1;
          m_lock = 1;
        end
      end else if (s == (m_slot == 0)) begin
        m_ch[m_slot] = d;
        m_v[m_slot] = 1'b1;
        m_fd = (m_slot == 3);
        m_slot = (m_slot + 1) % 4;
      end else if (m_slot == 0) begin
        m_err = 1;
        m_lock = 0;
      end else begin
        m_err = 1;
        m_ch[0] = d;
        m_v = 4'b0001;
        m_slot = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    step(1, 1, 1, 1, 8'hFF);
    tests++;
    if ({ch_data, ch_valid, frame_done, sync_err, locked} !== 39'd0) begin
      fails++;
      $display("FAIL reset outs data=%h v=%b fd=%b err=%b lk=%b exp all 0", ch_data, ch_valid, frame_done, sync_err, locked);
    end
  endtask
  task automatic test_clean_frame();
    logic [3:0] ev[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] wd[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, i == 0, wd[i]);
      tests++;
      if (ch_valid !== ev[i] || frame_done !== (i == 3)) begin
        fails++;
        $display("FAIL clean slot%0d v=%b fd=%b exp v=%b fd=%b", i, ch_valid, frame_done, ev[i], i == 3);
      end
    end
    tests++;
    if (ch_data !== 32'h44332211 || locked !== 1'b1) begin
      fails++;
      $display("FAIL clean data=%h lk=%b exp 44332211 lk=1", ch_data, locked);
    end
    step(0, 1, 0, 0, 8'h00);
    tests++;
    if (ch_valid !== 4'b0000 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL clean idle v=%b fd=%b exp 0 0", ch_valid, frame_done);
    end
  endtask
  task automatic test_hunt_discard();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h55);
    tests++;
    if (ch_valid !== 4'b0000 || sync_err !== 1'b0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL hunt 55 v=%b err=%b lk=%b exp 0 0 0", ch_valid, sync_err, locked);
    end
    step(0, 1, 1, 0, 8'h66);
    tests++;
    if (ch_valid !== 4'b0000 || sync_err !== 1'b0 || ch_data !== 32'h0) begin
      fails++;
      $display("FAIL hunt 66 v=%b err=%b data=%h exp 0 0 0", ch_valid, sync_err, ch_data);
    end
    step(0, 1, 1, 1, 8'hAA);
    tests++;
    if (ch_valid !== 4'b0001 || ch_data !== 32'h000000AA || locked !== 1'b1) begin
      fails++;
      $display("FAIL hunt AA v=%b data=%h lk=%b exp 0001 000000aa 1", ch_valid, ch_data, locked);
    end
  endtask
  task automatic test_missing_sof();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h11);
    step(0, 1, 1, 0, 8'h22);
    step(0, 1, 1, 0, 8'h33);
    step(0, 1, 1, 0, 8'h44);
    step(0, 1, 1, 0, 8'h77);
    tests++;
    if (sync_err !== 1'b1 || ch_valid !== 4'b0000 || ch_data !== 32'h44332211 || locked !== 1'b0) begin
      fails++;
      $display("FAIL missing_sof err=%b v=%b data=%h lk=%b exp 1 0000 44332211 0", sync_err, ch_valid, ch_data, locked);
    end
    step(0, 1, 1, 0, 8'h12);
    tests++;
    if (sync_err !== 1'b0 || ch_valid !== 4'b0000) begin
      fails++;
      $display("FAIL missing_sof hunt err=%b v=%b exp 0 0000", sync_err, ch_valid);
    end
  endtask
  task automatic test_early_sof();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h11);
    step(0, 1, 1, 0, 8'h22);
    step(0, 1, 1, 1, 8'h99);
    tests++;
    if (sync_err !== 1'b1 || ch_valid !== 4'b0001 || ch_data !== 32'h00002299 || frame_done !== 1'b0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL early_sof err=%b v=%b data=%h fd=%b lk=%b exp 1 0001 00002299 0 1", sync_err, ch_valid, ch_data, frame_done, locked);
    end
    step(0, 1, 1, 0, 8'h5A);
    tests++;
    if (ch_valid !== 4'b0010 || sync_err !== 1'b0 || ch_data !== 32'h00005A99) begin
      fails++;
      $display("FAIL early_sof next v=%b err=%b data=%h exp 0010 0 00005a99", ch_valid, sync_err, ch_data);
    end
  endtask
  task automatic test_gaps();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h11);
    step(0, 1, 0, 1, 8'hF0);
    tests++;
    if (ch_valid !== 4'b0000 || ch_data !== 32'h00000011) begin
      fails++;
      $display("FAIL gaps idle v=%b data=%h exp 0000 00000011", ch_valid, ch_data);
    end
    step(0, 1, 1, 0, 8'h22);
    step(0, 0, 1, 0, 8'hEE);
    tests++;
    if (ch_valid !== 4'b0000 || sync_err !== 1'b0 || ch_data !== 32'h00002211) begin
      fails++;
      $display("FAIL gaps enable v=%b err=%b data=%h exp 0000 0 00002211", ch_valid, sync_err, ch_data);
    end
    step(0, 1, 1, 0, 8'h33);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h44);
    tests++;
    if (ch_valid !== 4'b1000 || frame_done !== 1'b1 || ch_data !== 32'h44332211) begin
      fails++;
      $display("FAIL gaps end v=%b fd=%b data=%h exp 1000 1 44332211", ch_valid, frame_done, ch_data);
    end
  endtask
  task automatic test_reset_mid_frame();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 1, 8'h11);
    step(0, 1, 1, 0, 8'h22);
    step(1, 1, 1, 0, 8'h33);
    tests++;
    if ({ch_data, ch_valid, frame_done, sync_err, locked} !== 39'd0) begin
      fails++;
      $display("FAIL rst_mid data=%h v=%b fd=%b err=%b lk=%b exp all 0", ch_data, ch_valid, frame_done, sync_err, locked);
    end
    step(0, 1, 1, 0, 8'h44);
    tests++;
    if (ch_valid !== 4'b0000 || ch_data !== 32'h0 || locked !== 1'b0 || sync_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid next v=%b data=%h lk=%b err=%b exp 0 0 0 0", ch_valid, ch_data, locked, sync_err);
    end
  endtask
  task automatic test_random();
    int bad = 0;
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2000; i++) begin
      logic s;
      s = ($urandom_range(0, 7) == 0) ? 1'($urandom) : (m_slot == 0);
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, s, 8'($urandom));
      tests++;
      if (ch_data !== m_data() || ch_valid !== m_v || frame_done !== m_fd || sync_err !== m_err || locked !== m_lock) begin
        fails++;
        if (bad++ < 10)
          $display("FAIL random cyc%0d data=%h v=%b fd=%b err=%b lk=%b exp %h %b %b %b %b",
                   i, ch_data, ch_valid, frame_done, sync_err, locked, m_data(), m_v, m_fd, m_err, m_lock);
      end
    end
  endtask
  initial begin
    test_reset();
    test_clean_frame();
    test_hunt_discard();
    test_missing_sof();
    test_early_sof();
    test_gaps();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
